// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller around a single-port pipelined RAM macro.
// One macro access per cycle; read latency is absorbed by a small skid buffer.
module ram_fifo_ctrl #(
  parameter int DEPTH      = 128,
  parameter int AW         = 7,
  parameter int DW         = 16,
  parameter int READ_LAT   = 1,
  parameter int OBUF_DEPTH = READ_LAT + 2
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic [AW-1:0] ram_A,
  output logic [DW-1:0] ram_D,
  output logic          ram_WEN,
  output logic          ram_OEN,
  input  logic [DW-1:0] ram_Q
);

  // One spare bit so obuf_count + inflight_count cannot overflow.
  localparam int CW = $clog2(OBUF_DEPTH + 1) + 1;
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] OBUF_C  = CW'(OBUF_DEPTH);
  localparam logic [PW-1:0] OB_LAST = PW'(OBUF_DEPTH - 1);

  typedef enum logic {GR_READ = 1'b0, GR_WRITE = 1'b1} grant_e;

  logic [AW-1:0]       wr_ptr, rd_ptr, a_hold;
  logic [DW-1:0]       d_hold;
  logic [AW:0]         level_q;
  grant_e              last_grant;
  logic [READ_LAT-1:0] infl;
  logic [DW-1:0]       obuf_mem [OBUF_DEPTH];
  logic [PW-1:0]       ob_head, ob_tail;
  logic [CW-1:0]       ob_cnt, infl_cnt;
  logic                credit, rd_req, wr_gnt, rd_gnt, capture, pop;

  function automatic logic [PW-1:0] ob_next(input logic [PW-1:0] p);
    return (p == OB_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < READ_LAT; i++)
      infl_cnt = infl_cnt + {{(CW-1){1'b0}}, infl[i]};
  end

  // Reads are only issued when the skid buffer is guaranteed room on return.
  assign credit   = (ob_cnt + infl_cnt) < OBUF_C;
  assign rd_req   = (level_q != '0) && credit;
  assign in_ready = RSTN && (level_q < DEPTH_C) && !(rd_req && last_grant == GR_WRITE);
  assign wr_gnt   = in_valid && in_ready;
  assign rd_gnt   = rd_req && !wr_gnt;
  assign capture  = infl[READ_LAT-1];
  assign pop      = out_valid && out_ready;

  assign ram_A     = wr_gnt ? wr_ptr : (rd_gnt ? rd_ptr : a_hold);
  assign ram_D     = wr_gnt ? in_data : d_hold;
  assign ram_WEN   = !wr_gnt;
  assign ram_OEN   = 1'b1;
  assign out_valid = (ob_cnt != '0);
  assign out_data  = obuf_mem[ob_head];
  assign level     = level_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      a_hold     <= '0;
      d_hold     <= '0;
      level_q    <= '0;
      last_grant <= GR_READ;
      infl       <= '0;
      ob_head    <= '0;
      ob_tail    <= '0;
      ob_cnt     <= '0;
    end else begin
      if (wr_gnt) begin
        wr_ptr     <= wr_ptr + 1'b1;
        level_q    <= level_q + 1'b1;
        last_grant <= GR_WRITE;
        a_hold     <= wr_ptr;
        d_hold     <= in_data;
      end else if (rd_gnt) begin
        rd_ptr     <= rd_ptr + 1'b1;
        level_q    <= level_q - 1'b1;
        last_grant <= GR_READ;
        a_hold     <= rd_ptr;
      end
      for (int i = 1; i < READ_LAT; i++)
        infl[i] <= infl[i-1];
      infl[0] <= rd_gnt;
      if (capture) ob_tail <= ob_next(ob_tail);
      if (pop)     ob_head <= ob_next(ob_head);
      case ({capture, pop})
        2'b10:   ob_cnt <= ob_cnt + 1'b1;
        2'b01:   ob_cnt <= ob_cnt - 1'b1;
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (capture) obuf_mem[ob_tail] <= ram_Q;
  end

endmodule
